// File: rtl/tone_gen_if.sv
// Note-transfer channel between the CPU I/O store path and the tone generator.
// The CPU side drives a note (half-period plus duration) under a valid/ready handshake.
interface tone_gen_if #(
    parameter int PERIOD_W = 20,
    parameter int DUR_W    = 16
) ();
    logic                note_valid;
    logic                note_ready;
    logic [PERIOD_W-1:0] note_period;
    logic [DUR_W-1:0]    note_dur;

    modport master (
        output note_valid,
        output note_period,
        output note_dur,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_period,
        input  note_dur,
        output note_ready
    );
endinterface

// File: rtl/tone_gen.sv
// Square-wave note player: accepts one note at a time and drives Output_Sound for its duration.
// Optional macro TONE_GAP_EN inserts GAP_TICKS silent ticks after every note.
module tone_gen #(
    parameter int PERIOD_W  = 20,
    parameter int DUR_W     = 16,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 10
) (
    input  logic       clock,
    input  logic       reset,
    tone_gen_if.slave  note,
    input  logic       mute,
    output logic       Output_Sound,
    output logic       busy,
    output logic       note_done
);
    localparam int PC_W = (TICK_DIV > 32'sd1) ? $clog2(TICK_DIV) : 32'sd1;
    localparam int GT_W = (GAP_TICKS > 32'sd1) ? $clog2(GAP_TICKS + 32'sd1) : 32'sd1;
    // The tick counter is shared between note duration and the post-note gap.
    localparam int RT_W = (GT_W > DUR_W) ? GT_W : DUR_W;

    localparam logic [PERIOD_W-1:0] P_ONE    = PERIOD_W'(1'b1);
    localparam logic [RT_W-1:0]     RT_ONE   = RT_W'(1'b1);
    localparam logic [PC_W-1:0]     PC_ONE   = PC_W'(1'b1);
    localparam logic [PC_W-1:0]     PC_LAST  = PC_W'(TICK_DIV - 32'sd1);

`ifdef TONE_GAP_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1
    } state_t;
`endif

    state_t              state_r;
    logic [PERIOD_W-1:0] period_r;
    logic [PERIOD_W-1:0] hc_r;
    logic [PC_W-1:0]     pc_r;
    logic [RT_W-1:0]     rt_r;
    logic                sq_r;
    logic                sound_r;
    logic                done_r;

    logic [PERIOD_W-1:0] hc_next_s;
    logic                sq_next_s;
    logic                tick_wrap_s;
    logic                last_tick_s;

    // Half-period stepping and tick-boundary detection for the current note.
    always_comb begin
        hc_next_s   = hc_r;
        sq_next_s   = sq_r;
        tick_wrap_s = (pc_r == PC_LAST);
        last_tick_s = tick_wrap_s && (rt_r == RT_ONE);
        if (period_r == {PERIOD_W{1'b0}}) begin
            hc_next_s = {PERIOD_W{1'b0}};
            sq_next_s = 1'b0;
        end else if (hc_r == (period_r - P_ONE)) begin
            hc_next_s = {PERIOD_W{1'b0}};
            sq_next_s = ~sq_r;
        end else begin
            hc_next_s = hc_r + P_ONE;
            sq_next_s = sq_r;
        end
    end

    // Main FSM with all counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= S_IDLE;
            period_r <= {PERIOD_W{1'b0}};
            hc_r     <= {PERIOD_W{1'b0}};
            pc_r     <= {PC_W{1'b0}};
            rt_r     <= {RT_W{1'b0}};
            sq_r     <= 1'b0;
            sound_r  <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            sound_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (note.note_valid) begin
                        period_r <= note.note_period;
                        hc_r     <= {PERIOD_W{1'b0}};
                        pc_r     <= {PC_W{1'b0}};
                        sq_r     <= 1'b0;
                        rt_r     <= RT_W'(note.note_dur);
                        // A zero-length note completes immediately without playing.
                        if (note.note_dur == {DUR_W{1'b0}}) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r <= S_PLAY;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_PLAY: begin
                    pc_r <= tick_wrap_s ? {PC_W{1'b0}} : (pc_r + PC_ONE);
                    if (last_tick_s) begin
                        sq_r <= 1'b0;
                        hc_r <= {PERIOD_W{1'b0}};
`ifdef TONE_GAP_EN
                        if (GAP_TICKS != 32'sd0) begin
                            state_r <= S_GAP;
                            rt_r    <= RT_W'(GAP_TICKS);
                        end else begin
                            state_r <= S_IDLE;
                            done_r  <= 1'b1;
                        end
`else
                        state_r <= S_IDLE;
                        done_r  <= 1'b1;
`endif
                    end else begin
                        if (tick_wrap_s) begin
                            rt_r <= rt_r - RT_ONE;
                        end else begin
                            rt_r <= rt_r;
                        end
                        hc_r    <= hc_next_s;
                        sq_r    <= sq_next_s;
                        sound_r <= sq_next_s & ~mute;
                    end
                end
`ifdef TONE_GAP_EN
                S_GAP: begin
                    pc_r <= tick_wrap_s ? {PC_W{1'b0}} : (pc_r + PC_ONE);
                    if (last_tick_s) begin
                        state_r <= S_IDLE;
                        done_r  <= 1'b1;
                    end else if (tick_wrap_s) begin
                        rt_r <= rt_r - RT_ONE;
                    end else begin
                        rt_r <= rt_r;
                    end
                end
`endif
                default: begin
                    state_r <= S_IDLE;
                    sq_r    <= 1'b0;
                end
            endcase
        end
    end

    assign note.note_ready = (state_r == S_IDLE) && !reset;
    assign busy            = (state_r != S_IDLE);
    assign Output_Sound    = sound_r;
    assign note_done       = done_r;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen with TICK_DIV=4; cycle 0 is the cycle a note is offered.
module tb_tone_gen;
    localparam int PW = 20;
    localparam int DW = 16;
    localparam int TD = 4;
`ifdef TONE_GAP_EN
    localparam int GC = 4;
`else
    localparam int GC = 0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic mute;
    logic Output_Sound;
    logic busy;
    logic note_done;

    int tests = 0;
    int fails = 0;

    // Observed {Output_Sound, busy, note_done, note_ready} per cycle.
    logic [3:0] obs_a [0:31];

    tone_gen_if #(.PERIOD_W(PW), .DUR_W(DW)) nif ();

    tone_gen #(
        .PERIOD_W (PW),
        .DUR_W    (DW),
        .TICK_DIV (TD),
        .GAP_TICKS(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .note        (nif),
        .mute        (mute),
        .Output_Sound(Output_Sound),
        .busy        (busy),
        .note_done   (note_done)
    );

    always #5 clock = ~clock;

    // Offer a note in cycle 0 (and optionally again at offer2), record cycles 0..n.
    task automatic capture(input logic [PW-1:0] p, input logic [DW-1:0] d, input int n,
                           input int mute_on, input int rst_at, input int offer2);
        for (int c = 0; c <= n; c++) begin
            nif.note_valid  = (c == 0) || (c == offer2);
            nif.note_period = p;
            nif.note_dur    = d;
            if (c == mute_on) mute = 1'b1;
            reset = (c == rst_at);
            @(negedge clock);
            obs_a[c] = {Output_Sound, busy, note_done, nif.note_ready};
            @(posedge clock);
            #1;
        end
        nif.note_valid = 1'b0;
        reset = 1'b0;
        mute = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        mute = 1'b0;
        nif.note_valid = 1'b1;
        nif.note_period = 20'd3;
        nif.note_dur = 16'd2;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock);
            #1;
            @(negedge clock);
            tests++;
            if ({Output_Sound, busy, note_done, nif.note_ready} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_hold cycle %0d: got %b expected 0000", c,
                         {Output_Sound, busy, note_done, nif.note_ready});
            end
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        nif.note_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            tests++;
            if ({Output_Sound, busy, note_done, nif.note_ready} !== 4'b0001) begin
                fails++;
                $display("FAIL reset_release cycle %0d: got %b expected 0001", c,
                         {Output_Sound, busy, note_done, nif.note_ready});
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_tone;
        logic [3:0] exp;
        capture(20'd3, 16'd2, 9 + GC, -1, -1, -1);
        for (int c = 0; c <= 9 + GC; c++) begin
            exp[3] = (c >= 4) && (c <= 6);
            exp[2] = (c >= 1) && (c <= 8 + GC);
            exp[1] = (c == 9 + GC);
            exp[0] = !exp[2];
            tests++;
            if (obs_a[c] !== exp) begin
                fails++;
                $display("FAIL tone cycle %0d: got %b expected %b", c, obs_a[c], exp);
            end
        end
    endtask

    task automatic test_rest;
        logic [3:0] exp;
        capture(20'd0, 16'd1, 5 + GC, -1, -1, -1);
        for (int c = 0; c <= 5 + GC; c++) begin
            exp[3] = 1'b0;
            exp[2] = (c >= 1) && (c <= 4 + GC);
            exp[1] = (c == 5 + GC);
            exp[0] = !exp[2];
            tests++;
            if (obs_a[c] !== exp) begin
                fails++;
                $display("FAIL rest cycle %0d: got %b expected %b", c, obs_a[c], exp);
            end
        end
    endtask

    task automatic test_zero_dur;
        logic [3:0] exp;
        capture(20'd5, 16'd0, 2, -1, -1, -1);
        for (int c = 0; c <= 2; c++) begin
            exp = (c == 1) ? 4'b0011 : 4'b0001;
            tests++;
            if (obs_a[c] !== exp) begin
                fails++;
                $display("FAIL zero_dur cycle %0d: got %b expected %b", c, obs_a[c], exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp;
        int s;
        s = 9 + GC;
        capture(20'd3, 16'd2, 2 * s, -1, -1, s);
        for (int c = 0; c <= 2 * s; c++) begin
            exp[3] = ((c >= 4) && (c <= 6)) || ((c >= s + 4) && (c <= s + 6));
            exp[2] = ((c >= 1) && (c <= 8 + GC)) || ((c >= s + 1) && (c <= s + 8 + GC));
            exp[1] = (c == s) || (c == 2 * s);
            exp[0] = !exp[2];
            tests++;
            if (obs_a[c] !== exp) begin
                fails++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs_a[c], exp);
            end
        end
    endtask

    task automatic test_mute;
        logic [3:0] exp;
        capture(20'd3, 16'd2, 9 + GC, 5, -1, -1);
        for (int c = 0; c <= 9 + GC; c++) begin
            exp[3] = (c >= 4) && (c <= 5);
            exp[2] = (c >= 1) && (c <= 8 + GC);
            exp[1] = (c == 9 + GC);
            exp[0] = !exp[2];
            tests++;
            if (obs_a[c] !== exp) begin
                fails++;
                $display("FAIL mute cycle %0d: got %b expected %b", c, obs_a[c], exp);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [3:0] exp;
        capture(20'd3, 16'd2, 8, -1, 5, 6);
        for (int c = 0; c <= 8; c++) begin
            exp[3] = (c >= 4) && (c <= 5);
            exp[2] = ((c >= 1) && (c <= 5)) || (c >= 7);
            exp[1] = 1'b0;
            exp[0] = !exp[2];
            tests++;
            if (obs_a[c] !== exp) begin
                fails++;
                $display("FAIL mid_reset cycle %0d: got %b expected %b", c, obs_a[c], exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        mute = 1'b0;
        nif.note_valid = 1'b0;
        nif.note_period = '0;
        nif.note_dur = '0;
        test_reset();
        test_tone();
        test_rest();
        test_zero_dur();
        test_back_to_back();
        test_mute();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Note-playback engine directly downstream of the CPU core; drives the board's Output_Sound pin.
- The CPU's I/O store path hands it one note at a time (half-period plus duration) over a valid/ready handshake.
- The block generates a square wave for the programmed duration, then signals completion so the next note can be issued.
- Sits between the CPU datapath and the top-level Output_Sound port.

Parameters:
- PERIOD_W, 20, width of note_period (half-period in clock cycles).
- DUR_W, 16, width of note_dur (duration in ticks).
- TICK_DIV, 50000, clock cycles per duration tick (1 ms at 50 MHz); must be >= 1.
- GAP_TICKS, 10, silent ticks inserted after each note (used only with TONE_GAP_EN).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- note_valid  in  1  CPU offers a note.
- note_ready  out  1  block can accept a note.
- note_period  in  PERIOD_W  half-period in clocks; 0 = rest (silence).
- note_dur  in  DUR_W  duration in ticks.
- mute  in  1  forces Output_Sound low; timing is unaffected.
- Output_Sound  out  1  square-wave audio output.
- busy  out  1  high while not in IDLE.
- note_done  out  1  one-cycle pulse when a note (and its gap, if any) has finished.

Behaviour:
- One clock domain: clock. Reset is synchronous and active-high on reset.
- Reset (any cycle, including mid-note):
  - Next state IDLE; all counters 0.
  - Output_Sound=0, note_done=0, busy=0.
  - note_ready=0 while reset is high; note_ready=1 the first cycle after reset deasserts.
- FSM states: IDLE, PLAY, GAP (GAP exists only with the macro).
- IDLE:
  - note_ready=1.
  - A transfer occurs on an edge where note_valid && note_ready; period and duration are registered.
  - Inputs are ignored when no transfer occurs.
- Transfer with note_dur==0:
  - Stay in IDLE.
  - note_done pulses the next cycle.
  - Output_Sound stays 0.
- Transfer with note_dur>0:
  - Enter PLAY on the next cycle.
  - Half-period counter hc=0, prescaler pc=0, remaining ticks rt=note_dur, square-wave register sq=0.
- PLAY, half-period counter:
  - If period!=0: hc increments each cycle; when hc==period-1, hc wraps to 0 and sq toggles.
  - period==1 toggles every cycle.
  - If period==0: sq is held at 0.
- PLAY, duration:
  - pc counts 0..TICK_DIV-1 and wraps.
  - On each wrap, rt decrements.
  - On the wrap where rt==1: leave PLAY (to IDLE, or GAP with the macro), sq forced to 0.
  - Total PLAY length is exactly note_dur*TICK_DIV cycles.
- Output_Sound = sq & ~mute, registered; it is 0 outside PLAY.
- note_done:
  - Registered, high for exactly one cycle: the first IDLE cycle after PLAY/GAP.
  - note_ready is 1 in that same cycle, so back-to-back notes may be accepted with no bubble.
- busy = (state!=IDLE).
- note_ready=0 in PLAY and GAP; note_valid is ignored there.
- Counter arithmetic:
  - Unsigned; compares are done at full PERIOD_W/DUR_W width.
  - pc width is clog2(TICK_DIV), minimum 1.

Optional Feature:
- Macro TONE_GAP_EN.
- Defined:
  - After PLAY, enter GAP for GAP_TICKS*TICK_DIV cycles, with Output_Sound=0, busy=1, note_ready=0.
  - Then IDLE with the note_done pulse.
  - GAP_TICKS==0 skips GAP entirely.
- Undefined:
  - The GAP state and its counter are not compiled.
  - PLAY goes directly to IDLE.

Test Plan (TICK_DIV=4, macro undefined unless stated):
- Reset: reset=1 for 2 cycles with note_valid=1 -> Output_Sound=0, busy=0, note_done=0, note_ready=0 during reset and 1 the cycle after; no note accepted.
- Tone: accept period=3, dur=2 at cycle 0.
  - PLAY covers cycles 1-8 (busy=1).
  - Output_Sound=0 in cycles 1-3, 1 in 4-6, 0 in 7-8.
  - note_done=1 and note_ready=1 in cycle 9 only.
- Rest and zero-length:
  - period=0, dur=1 -> Output_Sound stays 0 for 4 busy cycles, note_done in cycle 5.
  - dur=0 -> busy never rises, note_done in cycle 1.
- Back-to-back and mute:
  - Second note offered in the note_done cycle is accepted that cycle, with no idle gap.
  - mute=1 mid-note -> Output_Sound=0 while the note still ends at the same cycle.
- Reset mid-note: reset in cycle 5 of the period=3, dur=2 note -> cycle 6 Output_Sound=0, busy=0, no note_done pulse; a new note is accepted in cycle 6.
- TONE_GAP_EN with GAP_TICKS=1: the tone test yields PLAY cycles 1-8, GAP cycles 9-12 (Output_Sound=0, note_ready=0), note_done in cycle 13.
